// File: rtl/vid_stream_mux_sync.sv
// Registered N-channel video selector. Source changes are deferred to the
// active channel's frame boundary, with a watchdog forcing stalled switches.
module vid_stream_mux_sync #(
  parameter int N           = 3,
  parameter int PIX_W       = 24,
  parameter int SEL_W       = $clog2(N),
  parameter int INIT_SEL    = 0,
  parameter int VS_ACTIVE   = 1,
  parameter int TIMEOUT_CYC = 2000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N*PIX_W-1:0] pixel_in,
  input  logic [N-1:0]       h_sync_in,
  input  logic [N-1:0]       v_sync_in,
  input  logic [N-1:0]       de_in,
  input  logic [SEL_W-1:0]   sel,
  input  logic               force_black,
  output logic [PIX_W-1:0]   pixel_out,
  output logic               h_sync_out,
  output logic               v_sync_out,
  output logic               de_out,
  output logic [SEL_W-1:0]   active_sel,
  output logic               switch_pending,
  output logic               switch_timeout,
  output logic               sel_err
);

  localparam int               CNT_W    = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [SEL_W-1:0] INIT_IDX = SEL_W'(INIT_SEL);
  localparam logic             VS_LVL   = (VS_ACTIVE != 0);

  typedef enum logic {
    LOCKED  = 1'b0,
    PENDING = 1'b1
  } state_t;

  state_t             state_reg, state_next;
  logic [SEL_W-1:0]   sel_q_reg;
  logic [SEL_W-1:0]   active_reg, active_next;
  logic [SEL_W-1:0]   target_reg, target_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               vs_prev_reg, vs_prev_next;
  logic               timeout_reg, timeout_next;

  logic [PIX_W-1:0]   pixel_reg;
  logic               h_sync_reg;
  logic               v_sync_reg;
  logic               de_reg;

  logic [PIX_W-1:0]   pix_ch [N];
  logic               sel_valid;
  logic               vs_act;
  logic               vs_tgt;
  logic               vs_edge;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_split
      assign pix_ch[gi] = pixel_in[gi*PIX_W +: PIX_W];
    end
  endgenerate

  assign sel_valid = (int'(sel_q_reg) < N);
  assign vs_act    = v_sync_in[active_reg];
  assign vs_tgt    = v_sync_in[target_reg];
  assign vs_edge   = (vs_act == VS_LVL) && (vs_prev_reg != VS_LVL);

  // Next-state logic; cancel has priority over a frame edge, edge over timeout.
  always_comb begin
    state_next   = state_reg;
    active_next  = active_reg;
    target_next  = target_reg;
    cnt_next     = cnt_reg;
    vs_prev_next = vs_act;
    timeout_next = 1'b0;

    case (state_reg)
      LOCKED: begin
        cnt_next = '0;
        if (sel_valid && (sel_q_reg != active_reg)) begin
          target_next = sel_q_reg;
          state_next  = PENDING;
        end
      end
      PENDING: begin
        if (sel_valid && (sel_q_reg == active_reg)) begin
          state_next = LOCKED;
          cnt_next   = '0;
        end else if (vs_edge || (cnt_reg == CNT_LAST)) begin
          active_next  = target_reg;
          vs_prev_next = vs_tgt;
          timeout_next = !vs_edge;
          state_next   = LOCKED;
          cnt_next     = '0;
        end else begin
          if (sel_valid) begin
            target_next = sel_q_reg;
          end
          if (cnt_reg != CNT_MAX) begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end
      default: begin
        state_next = LOCKED;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= LOCKED;
      sel_q_reg   <= INIT_IDX;
      active_reg  <= INIT_IDX;
      target_reg  <= INIT_IDX;
      cnt_reg     <= '0;
      vs_prev_reg <= v_sync_in[INIT_IDX];
      timeout_reg <= 1'b0;
      pixel_reg   <= '0;
      h_sync_reg  <= 1'b0;
      v_sync_reg  <= 1'b0;
      de_reg      <= 1'b0;
    end else begin
      state_reg   <= state_next;
      sel_q_reg   <= sel;
      active_reg  <= active_next;
      target_reg  <= target_next;
      cnt_reg     <= cnt_next;
      vs_prev_reg <= vs_prev_next;
      timeout_reg <= timeout_next;
      // Whole output word is taken from one channel index, so no mixing.
      pixel_reg   <= force_black ? '0 : pix_ch[active_reg];
      h_sync_reg  <= h_sync_in[active_reg];
      v_sync_reg  <= v_sync_in[active_reg];
      de_reg      <= de_in[active_reg];
    end
  end

  assign pixel_out      = pixel_reg;
  assign h_sync_out     = h_sync_reg;
  assign v_sync_out     = v_sync_reg;
  assign de_out         = de_reg;
  assign active_sel     = active_reg;
  assign switch_pending = (state_reg == PENDING);
  assign switch_timeout = timeout_reg;
  assign sel_err        = !sel_valid;

endmodule

// File: doc/vid_stream_mux_sync.md
Name: vid_stream_mux_sync

Overview:
- Registered N-channel video stream selector, the successor to the team's combinational pixel/sync mux.
- A new source selection takes effect only on a frame boundary: the rising v_sync edge of the currently active channel. This prevents torn frames and sync glitches at the HDMI/VGA output.
- A watchdog forces the switch if the active source stops producing v_sync.
- Sits between the parallel video processing chains and the output encoder.

Parameters:
- N, 3, number of input streams (2..16)
- PIX_W, 24, pixel width in bits
- SEL_W, $clog2(N), select width
- INIT_SEL, 0, channel active after reset (must be < N)
- VS_ACTIVE, 1, v_sync active level; frame boundary = transition into this level
- TIMEOUT_CYC, 2000000, cycles without an active-channel frame boundary before a pending switch is forced (>= 2)

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous, active-high reset
- pixel_in  in  N*PIX_W  channel k occupies bits [k*PIX_W +: PIX_W]
- h_sync_in  in  N  per-channel h_sync
- v_sync_in  in  N  per-channel v_sync
- de_in  in  N  per-channel data enable
- sel  in  SEL_W  requested channel (level, may change any cycle)
- force_black  in  1  forces pixel_out to 0; syncs and de unaffected
- pixel_out  out  PIX_W  registered pixel
- h_sync_out  out  1  registered h_sync
- v_sync_out  out  1  registered v_sync
- de_out  out  1  registered de
- active_sel  out  SEL_W  channel currently routed
- switch_pending  out  1  high while a valid request != active_sel is waiting
- switch_timeout  out  1  one-cycle pulse when a switch is forced by the watchdog
- sel_err  out  1  high while registered sel >= N

Behaviour:
- Reset (rst=1 at a clk edge):
  - pixel_out=0, h_sync_out=0, v_sync_out=0, de_out=0
  - active_sel=INIT_SEL, switch_pending=0, switch_timeout=0, sel_err=0
  - sel_q=INIT_SEL, state=LOCKED, watchdog counter=0
  - vs_prev = v_sync_in[INIT_SEL] level sampled at that edge
  - Reset mid-pending cancels the request.
- Datapath latency is 1 cycle. Outputs at cycle t+1 = inputs of channel active_sel at cycle t. pixel_out = 0 if force_black was high at cycle t.
- Select input:
  - sel is registered into sel_q (1 cycle).
  - sel_q >= N: sel_err=1 and the request is ignored. Target and state are unchanged.
- Frame-boundary edge:
  - vs_edge = (v_sync_in[active_sel]==VS_ACTIVE) && (vs_prev!=VS_ACTIVE).
  - vs_prev is updated every cycle from the active channel.
- State LOCKED:
  - Valid sel_q != active_sel -> latch target=sel_q, go to PENDING. The counter is cleared and switch_pending=1 from the next cycle.
- State PENDING:
  - Target tracks the latest valid sel_q.
  - Valid sel_q == active_sel -> cancel: go to LOCKED, switch_pending=0.
  - vs_edge -> active_sel<=target at the end of that cycle. The edge cycle's output therefore still comes from the old channel. The new channel is output from the following cycle. Go to LOCKED.
  - On switch, vs_prev is loaded with v_sync_in[target] so no false edge is seen on the new channel.
  - Counter increments each PENDING cycle. Reaching TIMEOUT_CYC-1 without an edge forces the same switch and pulses switch_timeout for 1 cycle.
  - Edge and timeout in the same cycle: treat as edge, no timeout pulse.
  - Cancel and edge in the same cycle: cancel wins, no switch.
- active_sel only changes on a switch event. Outputs never mix channels within one cycle.
- The watchdog counter is ceil(log2(TIMEOUT_CYC)) bits wide, saturates, and is held at 0 in LOCKED.

Test Plan:
- Reset then steady state: N=3, INIT_SEL=0, channel 0 pixel=0x123456, de=1 -> after 1 cycle pixel_out=0x123456, de_out=1, active_sel=0, switch_pending=0.
- Frame-aligned switch: sel=2 at cycle 10, channel 0 v_sync rises at cycle 50 -> switch_pending=1 cycles 12..50, active_sel=2 from cycle 51, pixel_out shows channel 2 data from cycle 52, no switch_timeout.
- Cancel: sel 0->1 then back to 0 before any v_sync edge -> switch_pending returns to 0, active_sel stays 0, outputs never show channel 1.
- Retarget and out-of-range: sel=1 then 2 while pending, then sel=3 -> sel_err=1 while sel_q=3; the next v_sync edge switches to 2.
- Watchdog: TIMEOUT_CYC=100, channel 0 v_sync held low, sel=1 -> switch_timeout pulses once ~100 cycles after pending starts, active_sel=1, state LOCKED.
- force_black with mid-pending reset: force_black=1 -> pixel_out=0 while h/v_sync and de follow the source; rst asserted while pending -> next cycle all outputs 0, active_sel=INIT_SEL, switch_pending=0.
